// File: rtl/button_repeater.sv
// button_repeater: multi-channel push-button conditioner with typematic auto-repeat.
// Each channel synchronises its raw button, debounces the press, emits a one-cycle
// press pulse on acceptance, then after a hold time runs a square-wave repeat with
// a press pulse on every rising edge of level.
//
// Ports:
//   uclock    - system clock, all logic on the rising edge
//   reset     - synchronous active-high reset
//   btn_in    - raw asynchronous button levels, active-high, one bit per channel
//   level     - conditioned level: high while held, square wave while repeating
//   press     - one-cycle pulse on acceptance and on every repeat
//   repeating - high while the channel is auto-repeating
//
// Optional feature: define REPEAT_ACCEL_EN to halve the repeat period (and high
// point) after every ACCEL_STEPS repeats, down to a floor of PERIOD_CYC>>2.
// With the macro undefined the period is fixed and no repeat counter exists.
//
// Latency: btn_in to FSM is 2 cycles of synchroniser; all outputs are registered.
// No backpressure: outputs are free-running pulses/levels.

module button_repeater #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 26,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int HOLD_CYC     = 50_000_000,
  parameter int PERIOD_CYC   = 6_000_000,
  parameter int HIGH_CYC     = 3_000_000,
  parameter int ACCEL_STEPS  = 8
) (
  input  logic                uclock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] repeating
);

  // Terminal counts and nominal repeat timing, sized to the counter width.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] PER_NOM   = CNT_W'(PERIOD_CYC);
  localparam logic [CNT_W-1:0] HIGH_NOM  = CNT_W'(HIGH_CYC);

`ifdef REPEAT_ACCEL_EN
  localparam logic [CNT_W-1:0] PER_FLOOR = CNT_W'(PERIOD_CYC >> 2);
  localparam int               STEP_W    = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ACCEL_STEPS - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_REPEAT
  } state_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

    logic             sync1;
    logic             btn_s;
    state_t           state;
    // Shared counter: debounce/hold count outside REPEAT, phase inside REPEAT.
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             rep_q;

    // Active period and high point for this channel.
    logic [CNT_W-1:0] per_cur;
    logic [CNT_W-1:0] high_cur;
    logic [CNT_W-1:0] per_nxt;
    logic [CNT_W-1:0] high_nxt;

    logic             wrap;
    logic [CNT_W-1:0] phase_nxt;

`ifdef REPEAT_ACCEL_EN
    logic [CNT_W-1:0]  per_q;
    logic [CNT_W-1:0]  high_q;
    logic [STEP_W-1:0] rep_cnt;
    // Set once ACCEL_STEPS repeats have been seen; consumed at the next wrap
    // so a period is never cut short mid-cycle.
    logic              accel_pend;

    assign per_cur  = per_q;
    assign high_cur = high_q;

    always_comb begin
      per_nxt  = per_cur;
      high_nxt = high_cur;
      if (wrap && accel_pend && (per_cur > PER_FLOOR)) begin
        per_nxt  = per_cur >> 1;
        high_nxt = high_cur >> 1;
      end
    end

    // Acceleration state only lives while the button is held in REPEAT;
    // anything else (release, other states, reset) restores nominal timing.
    always_ff @(posedge uclock) begin
      if (reset || !(state == ST_REPEAT && btn_s)) begin
        per_q      <= PER_NOM;
        high_q     <= HIGH_NOM;
        rep_cnt    <= '0;
        accel_pend <= 1'b0;
      end else begin
        per_q  <= per_nxt;
        high_q <= high_nxt;
        if (wrap) begin
          accel_pend <= 1'b0;
        end
        // A repeat pulse on the same edge as a wrap still arms the next step.
        if (phase_nxt == high_nxt) begin
          if (rep_cnt == STEP_LAST) begin
            rep_cnt    <= '0;
            accel_pend <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + STEP_W'(1);
          end
        end
      end
    end
`else
    assign per_cur  = PER_NOM;
    assign high_cur = HIGH_NOM;
    assign per_nxt  = PER_NOM;
    assign high_nxt = HIGH_NOM;
`endif

    always_comb begin
      wrap      = (cnt == per_cur - CNT_W'(1));
      phase_nxt = wrap ? '0 : cnt + CNT_W'(1);
    end

    // Channel FSM. Release (btn_s low) is checked before any terminal count so
    // a release coinciding with acceptance or repeat entry suppresses it.
    always_ff @(posedge uclock) begin
      if (reset) begin
        sync1   <= 1'b0;
        btn_s   <= 1'b0;
        state   <= ST_IDLE;
        cnt     <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        sync1   <= btn_in[ch];
        btn_s   <= sync1;
        press_q <= 1'b0;

        case (state)
          ST_IDLE: begin
            cnt     <= '0;
            level_q <= 1'b0;
            rep_q   <= 1'b0;
            if (btn_s) begin
              state <= ST_DEBOUNCE;
            end
          end

          ST_DEBOUNCE: begin
            if (!btn_s) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state   <= ST_HELD;
              cnt     <= '0;
              press_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_HELD: begin
            if (!btn_s) begin
              state   <= ST_IDLE;
              cnt     <= '0;
              level_q <= 1'b0;
            end else if (cnt == HOLD_LAST) begin
              // Phase 0 is always below the high point, so level drops here.
              state   <= ST_REPEAT;
              cnt     <= '0;
              level_q <= 1'b0;
              rep_q   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          ST_REPEAT: begin
            if (!btn_s) begin
              state   <= ST_IDLE;
              cnt     <= '0;
              level_q <= 1'b0;
              rep_q   <= 1'b0;
            end else begin
              // Outputs track the phase being entered so they line up with it.
              cnt     <= phase_nxt;
              level_q <= (phase_nxt >= high_nxt);
              press_q <= (phase_nxt == high_nxt);
              rep_q   <= 1'b1;
            end
          end

          default: begin
            state   <= ST_IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            rep_q   <= 1'b0;
          end
        endcase
      end
    end

    assign level[ch]     = level_q;
    assign press[ch]     = press_q;
    assign repeating[ch] = rep_q;

  end : g_ch

endmodule

// File: tb/tb_button_repeater.sv
// Self-checking bench for button_repeater: table of single-channel press lengths
// with hand-computed summary statistics, a per-cycle two-channel sequence with a
// mid-repeat reset, and (with REPEAT_ACCEL_EN) the accelerated repeat schedule.

module tb_button_repeater;

  localparam int CH = 2;

  logic          uclock = 1'b0;
  logic          reset;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] repeating;

  int checks = 0;
  int errors = 0;

  button_repeater #(
    .CHANNELS    (CH),
    .CNT_W       (8),
    .DEBOUNCE_CYC(4),
    .HOLD_CYC    (20),
    .PERIOD_CYC  (8),
    .HIGH_CYC    (4),
    .ACCEL_STEPS (2)
  ) dut (
    .uclock   (uclock),
    .reset    (reset),
    .btn_in   (btn_in),
    .level    (level),
    .press    (press),
    .repeating(repeating)
  );

  always #5 uclock = ~uclock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge uclock);
    #1;
  endtask

  // Expected {level, press, repeating} for a channel held continuously,
  // r cycles after its t0, with nominal timing (debounce 4, hold 20, P 8, H 4).
  function automatic logic [2:0] held_model(input int r);
    int ph;
    if (r < 4) return 3'b000;
    if (r < 24) return {1'b1, (r == 4), 1'b0};
    ph = (r - 24) % 8;
    return {(ph >= 4), (ph == 4), 1'b1};
  endfunction

  typedef struct {
    int len;
    int n_press;
    int first_press;
    int last_press;
    int n_level;
    int n_rep;
    int first_rep;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n_press, first_press, last_press, n_level, n_rep, first_rep, ch1_act;
    int rel;
    logic [2:0] e0, e1;

    // len = cycles btn_in[0] is high; offsets are relative to t0.
    vecs[0] = '{3,  0, -1, -1,  0,  0, -1};  // glitch
    vecs[1] = '{4,  0, -1, -1,  0,  0, -1};  // release on debounce terminal cycle
    vecs[2] = '{5,  1,  4,  4,  1,  0, -1};  // shortest accepted press
    vecs[3] = '{15, 1,  4,  4, 11,  0, -1};  // single press
    vecs[4] = '{24, 1,  4,  4, 20,  0, -1};  // release on hold terminal cycle
    vecs[5] = '{25, 1,  4,  4, 20,  1, 24};  // one cycle of REPEAT
    vecs[6] = '{60, 5,  4, 52, 36, 36, 24};  // full hold

    reset  = 1'b1;
    btn_in = '0;
    tick();
    tick();
    tick();
    check("reset_level", 32'(level), 0);
    check("reset_press", 32'(press), 0);
    check("reset_repeating", 32'(repeating), 0);
    reset = 1'b0;
    tick();

    // Table: press channel 0 for len cycles and gather statistics.
    for (int i = 0; i < 7; i++) begin
      n_press = 0; first_press = -1; last_press = -1;
      n_level = 0; n_rep = 0; first_rep = -1; ch1_act = 0;
      btn_in[0] = 1'b1;
      for (int c = 1; c <= vecs[i].len + 8; c++) begin
        tick();
        rel = c - 3;
        if (press[0]) begin
          n_press++;
          if (first_press < 0) first_press = rel;
          last_press = rel;
        end
        if (level[0]) n_level++;
        if (repeating[0]) begin
          n_rep++;
          if (first_rep < 0) first_rep = rel;
        end
        if (level[1] || press[1] || repeating[1]) ch1_act++;
        if (c == vecs[i].len) btn_in[0] = 1'b0;
      end
      check($sformatf("v%0d_n_press", i), n_press, vecs[i].n_press);
      check($sformatf("v%0d_first_press", i), first_press, vecs[i].first_press);
      check($sformatf("v%0d_last_press", i), last_press, vecs[i].last_press);
      check($sformatf("v%0d_n_level", i), n_level, vecs[i].n_level);
      check($sformatf("v%0d_n_rep", i), n_rep, vecs[i].n_rep);
      check($sformatf("v%0d_first_rep", i), first_rep, vecs[i].first_rep);
      check($sformatf("v%0d_ch1_quiet", i), ch1_act, 0);
      check($sformatf("v%0d_idle_after", i), 32'({level, press, repeating}), 0);
    end

    // Two channels, ch1 three cycles behind; reset sampled at t0+30.
    // Both buttons are still high through reset, so both restart together
    // with a new t0 of 33 (two synchroniser cycles plus the IDLE edge).
    btn_in[0] = 1'b1;
    for (int c = 1; c <= 103; c++) begin
      tick();
      rel = c - 3;
      if (rel < 30) begin
        e0 = held_model(rel);
        e1 = held_model(rel - 3);
      end else begin
        e0 = held_model(rel - 33);
        e1 = held_model(rel - 33);
      end
      check($sformatf("ind_ch0_t%0d", rel), 32'({level[0], press[0], repeating[0]}), 32'(e0));
      check($sformatf("ind_ch1_t%0d", rel), 32'({level[1], press[1], repeating[1]}), 32'(e1));
      if (c == 3) btn_in[1] = 1'b1;
      if (rel == 29) reset = 1'b1;
      if (rel == 30) reset = 1'b0;
    end
    btn_in = '0;
    for (int c = 0; c < 4; c++) tick();
    check("ind_release_idle", 32'({level, press, repeating}), 0);
    for (int c = 0; c < 4; c++) tick();

`ifdef REPEAT_ACCEL_EN
    begin
      int got[$];
      int exp_q[$];
      // Hold for 80: P 8 -> 4 after two repeats, -> 2 after four, then floor.
      exp_q = '{4, 28, 36, 42, 46};
      for (int t = 49; t <= 79; t += 2) exp_q.push_back(t);
      btn_in[0] = 1'b1;
      for (int c = 1; c <= 90; c++) begin
        tick();
        if (press[0]) got.push_back(c - 3);
        if (c == 80) btn_in[0] = 1'b0;
      end
      check("acc_n_press", got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
        check($sformatf("acc_press%0d", k), got[k], exp_q[k]);

      // Re-press: timing must be back to nominal period 8.
      got.delete();
      exp_q = '{4, 28, 36};
      btn_in[0] = 1'b1;
      for (int c = 1; c <= 48; c++) begin
        tick();
        if (press[0]) got.push_back(c - 3);
        if (c == 40) btn_in[0] = 1'b0;
      end
      check("acc2_n_press", got.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
        check($sformatf("acc2_press%0d", k), got[k], exp_q[k]);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
